// File: rtl/key_sw_io_device.sv
// Memory-mapped KEY/SW input responder: synchronizes and debounces both groups,
// keeps sticky Ready/Overrun/IE per group, and decodes CPU loads/stores.
module key_sw_io_device #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDRKEY         = DBITS'(32'hF0000010),
  parameter logic [DBITS-1:0] ADDRSW          = DBITS'(32'hF0000014),
  parameter logic [DBITS-1:0] ADDRKCTRL       = DBITS'(32'hF0000110),
  parameter logic [DBITS-1:0] ADDRSCTRL       = DBITS'(32'hF0000114),
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               CNTBITS         = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrdata,
  input  logic             we,
  input  logic             re,
  output logic [DBITS-1:0] rddata,
  output logic             hit,
  output logic             irq
);
  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);

  // Group 0 is KEY (inverted, zero-extended to 10 bits), group 1 is SW.
  logic [9:0]         raw   [2];
  logic [9:0]         s1_q  [2];
  logic [9:0]         s2_q  [2];
  logic [9:0]         s3_q  [2];
  logic [9:0]         deb_q [2];
  logic [9:0]         deb_d [2];
  logic [CNTBITS-1:0] cnt_q [2];
  logic [CNTBITS-1:0] cnt_d [2];
  logic [1:0]         chg, rd_clr, ctrl_wr;
  logic [1:0]         rdy_q, rdy_d, ovr_q, ovr_d, ie_q, ie_d;
  logic               sel_kd, sel_sd, sel_kc, sel_sc;
  logic               unused_wrdata;

  assign raw[0] = {6'b0, ~KEY};
  assign raw[1] = SW;

  assign sel_kd  = (addr == ADDRKEY);
  assign sel_sd  = (addr == ADDRSW);
  assign sel_kc  = (addr == ADDRKCTRL);
  assign sel_sc  = (addr == ADDRSCTRL);
  assign hit     = sel_kd | sel_sd | sel_kc | sel_sc;
  assign rd_clr  = {re & sel_sd, re & sel_kd};
  assign ctrl_wr = {we & sel_sc, we & sel_kc};
  assign irq     = |(rdy_q & ie_q);
  assign unused_wrdata = ^{wrdata[DBITS-1:5], wrdata[3], wrdata[1:0]};

  always_comb begin
    chg   = '0;
    rdy_d = rdy_q;
    ovr_d = ovr_q;
    ie_d  = ie_q;
    for (int g = 0; g < 2; g++) begin
      deb_d[g] = deb_q[g];
      cnt_d[g] = cnt_q[g] + CNTBITS'(1);
      if (s2_q[g] == deb_q[g] || s2_q[g] != s3_q[g]) begin
        cnt_d[g] = '0;
      end else if (cnt_q[g] == CNT_LAST) begin
        deb_d[g] = s2_q[g];
        cnt_d[g] = '0;
        chg[g]   = 1'b1;
      end
      if (ctrl_wr[g]) begin
        ie_d[g] = wrdata[4];
        if (!wrdata[2]) ovr_d[g] = 1'b0;
      end
      // A landing change beats a same-edge read clear and then is not an overrun.
      if (chg[g]) begin
        rdy_d[g] = 1'b1;
        if (rdy_q[g] && !rd_clr[g]) ovr_d[g] = 1'b1;
      end else if (rd_clr[g]) begin
        rdy_d[g] = 1'b0;
      end
    end
  end

  always_comb begin
    rddata = '0;
    if (sel_kd)      rddata[9:0] = deb_q[0];
    else if (sel_sd) rddata[9:0] = deb_q[1];
    else if (sel_kc) rddata[4:0] = {ie_q[0], 1'b0, ovr_q[0], 1'b0, rdy_q[0]};
    else if (sel_sc) rddata[4:0] = {ie_q[1], 1'b0, ovr_q[1], 1'b0, rdy_q[1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int g = 0; g < 2; g++) begin
        s1_q[g]  <= '0;
        s2_q[g]  <= '0;
        s3_q[g]  <= '0;
        deb_q[g] <= '0;
        cnt_q[g] <= '0;
      end
      rdy_q <= '0;
      ovr_q <= '0;
      ie_q  <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        s1_q[g]  <= raw[g];
        s2_q[g]  <= s1_q[g];
        s3_q[g]  <= s2_q[g];
        deb_q[g] <= deb_d[g];
        cnt_q[g] <= cnt_d[g];
      end
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
      ie_q  <= ie_d;
    end
  end
endmodule

// File: tb/tb_key_sw_io_device.sv
// Bench for key_sw_io_device: sliding-window debounce model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_key_sw_io_device;
  localparam int          DC   = 4;
  localparam logic [31:0] A_KD = 32'hF0000010;
  localparam logic [31:0] A_SD = 32'hF0000014;
  localparam logic [31:0] A_KC = 32'hF0000110;
  localparam logic [31:0] A_SC = 32'hF0000114;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] addr, wrdata, rddata;
  logic        we, re, hit, irq;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  key_sw_io_device #(.DEBOUNCE_CYCLES(DC), .CNTBITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .KEY(KEY), .SW(SW), .addr(addr),
    .wrdata(wrdata), .we(we), .re(re), .rddata(rddata), .hit(hit), .irq(irq)
  );

  // Model: m_hist[g][i] is the raw sample taken i+1 edges ago. A new value is
  // accepted once it has been seen in DC+1 consecutive samples, two edges late.
  logic [9:0] m_hist [2][DC+2];
  logic [9:0] m_deb  [2];
  logic [9:0] m_smp  [2];
  bit         m_rdy  [2];
  bit         m_ovr  [2];
  bit         m_ie   [2];
  bit         m_ch, m_clr, m_wr;
  bit         started = 1'b0;

  initial forever begin
    @(posedge clk);
    started = 1'b1;
    if (!reset_n) begin
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < DC + 2; i++) m_hist[g][i] = '0;
        m_deb[g] = '0;
        m_rdy[g] = 1'b0;
        m_ovr[g] = 1'b0;
        m_ie[g]  = 1'b0;
      end
    end else begin
      m_smp[0] = {6'b0, ~KEY};
      m_smp[1] = SW;
      for (int g = 0; g < 2; g++) begin
        m_ch = (m_hist[g][1] != m_deb[g]);
        for (int i = 2; i <= DC + 1; i++)
          if (m_hist[g][i] != m_hist[g][1]) m_ch = 1'b0;
        m_clr = re && (addr == ((g == 0) ? A_KD : A_SD));
        m_wr  = we && (addr == ((g == 0) ? A_KC : A_SC));
        if (m_wr) begin
          m_ie[g] = wrdata[4];
          if (!wrdata[2]) m_ovr[g] = 1'b0;
        end
        if (m_ch) begin
          if (m_rdy[g] && !m_clr) m_ovr[g] = 1'b1;
          m_rdy[g] = 1'b1;
          m_deb[g] = m_hist[g][1];
        end else if (m_clr) begin
          m_rdy[g] = 1'b0;
        end
        for (int i = DC + 1; i > 0; i--) m_hist[g][i] = m_hist[g][i-1];
        m_hist[g][0] = m_smp[g];
      end
    end
  end

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    if (a == A_KD) return {22'b0, m_deb[0]};
    if (a == A_SD) return {22'b0, m_deb[1]};
    if (a == A_KC) return {27'b0, m_ie[0], 1'b0, m_ovr[0], 1'b0, m_rdy[0]};
    if (a == A_SC) return {27'b0, m_ie[1], 1'b0, m_ovr[1], 1'b0, m_rdy[1]};
    return 32'b0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("model rddata", rddata, exp_rd(addr));
      check("model hit", {31'b0, hit},
            {31'b0, (addr == A_KD) || (addr == A_SD) || (addr == A_KC) || (addr == A_SC)});
      check("model irq", {31'b0, irq},
            {31'b0, (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1])});
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(string name, logic [31:0] a, logic [31:0] exp);
    addr = a;
    #1;
    check(name, rddata, exp);
  endtask

  task automatic bus_read(logic [31:0] a);
    addr = a;
    re   = 1'b1;
    step(1);
    re   = 1'b0;
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d);
    addr   = a;
    wrdata = d;
    we     = 1'b1;
    step(1);
    we     = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; KEY = 4'hF; SW = 10'h3FF;
    addr = '0; wrdata = '0; we = 1'b0; re = 1'b0;

    // Reset, then switches already on debounce from zero
    step(3);
    check("reset irq", {31'b0, irq}, 32'h0);
    peek("reset kctrl", A_KC, 32'h0);
    reset_n = 1'b1;
    step(6);
    peek("sdata before", A_SD, 32'h0);
    step(1);
    peek("sdata after", A_SD, 32'h3FF);
    peek("sctrl ready", A_SC, 32'h1);

    // Debounce latency on a key press
    bus_read(A_SD);
    KEY = 4'hE;
    step(6);
    peek("kdata E0+5", A_KD, 32'h0);
    step(1);
    peek("kdata E0+6", A_KD, 32'h1);
    peek("kctrl ready", A_KC, 32'h1);

    bus_read(A_KD);
    KEY = 4'hF;
    step(8);
    bus_read(A_KD);
    peek("kctrl cleared", A_KC, 32'h0);

    // Bounce: runs of two samples never qualify
    for (int i = 0; i < 10; i++) begin
      KEY[0] = ~KEY[0];
      step(2);
    end
    KEY = 4'hE;
    step(6);
    peek("bounce kdata pre", A_KD, 32'h0);
    step(1);
    peek("bounce kdata", A_KD, 32'h1);
    peek("bounce kctrl", A_KC, 32'h1);

    // Overrun on switches
    SW = 10'h0AA;
    step(8);
    SW = 10'h155;
    step(8);
    peek("sctrl overrun", A_SC, 32'h5);
    peek("sdata 155", A_SD, 32'h155);
    bus_write(A_SC, 32'h0);
    peek("sctrl ovr clr", A_SC, 32'h1);
    bus_read(A_SD);
    peek("sctrl rd clr", A_SC, 32'h0);

    // IRQ enable and read/set collision
    bus_read(A_KD);
    bus_write(A_KC, 32'h10);
    check("irq idle", {31'b0, irq}, 32'h0);
    KEY = 4'hF;
    step(7);
    check("irq set", {31'b0, irq}, 32'h1);
    KEY = 4'hE;
    step(6);
    addr = A_KD;
    re   = 1'b1;
    step(1);
    re   = 1'b0;
    peek("collision kctrl", A_KC, 32'h11);
    check("collision irq", {31'b0, irq}, 32'h1);

    // Decode
    peek("unmapped rddata", 32'hF0000018, 32'h0);
    check("unmapped hit", {31'b0, hit}, 32'h0);
    bus_write(A_KD, 32'hF);
    peek("kdata ro", A_KD, 32'h1);
    check("mapped hit", {31'b0, hit}, 32'h1);

    // Reset mid-debounce discards pending value, then re-debounces
    SW = 10'h3C0;
    step(3);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(6);
    peek("rst sdata pre", A_SD, 32'h0);
    step(1);
    peek("rst sdata", A_SD, 32'h3C0);
    peek("rst sctrl", A_SC, 32'h1);
    peek("rst kctrl", A_KC, 32'h1);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
